mips_fetch_queue: RTL and testbench

- Parametrised successor to the single-register IF stage: fetch unit with PC generator, instruction-memory request/response handshake and a DEPTH-entry prefetch queue feeding decode.
- Decouples memory latency from decode stalls.
- Supports branch/jump redirect with queue flush and squash of the in-flight response.
- Sits between instruction memory and the IF/ID boundary; each queue entry carries {instr, pc, pc+4}.

---
 rtl/mips_fetch_queue.sv | 152 +++++++++++++++
 tb/tb_mips_fetch_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_queue.sv
// rtl/mips_fetch_queue.sv - instruction fetch unit with PC generator and prefetch queue
//
// Purpose:
//   Generates sequential fetch addresses and runs a request/grant/response
//   handshake with instruction memory. Returned instructions go into a
//   DEPTH-entry prefetch queue that feeds decode, so memory latency is hidden
//   from decode stalls. A taken branch/jump flushes the queue and squashes
//   any response still in flight.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   redirect_valid   branch/jump taken this cycle
//   redirect_pc      redirect target (low two bits ignored)
//   imem_req         fetch request
//   imem_addr        fetch address, word aligned
//   imem_gnt         memory accepts the request this cycle
//   imem_rvalid      response valid
//   imem_rdata       fetched instruction
//   id_valid         queue head valid towards decode
//   id_ready         decode accepts the head
//   id_instr         head instruction
//   id_pc            head PC
//   id_pc_plus4      head PC+4
//   occupancy        number of queued entries
module mips_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0040
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic                         imem_gnt,
    input  logic                         imem_rvalid,
    input  logic [DATA_W-1:0]            imem_rdata,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [DATA_W-1:0]            id_instr,
    output logic [ADDR_W-1:0]            id_pc,
    output logic [ADDR_W-1:0]            id_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_C   = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] WORD_INC = ADDR_W'(4);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_outstanding;
    logic              r_discard;
    logic [OCC_W-1:0]  r_occ;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;

    logic [DATA_W-1:0] r_q_instr [DEPTH];
    logic [ADDR_W-1:0] r_q_pc    [DEPTH];
    logic [ADDR_W-1:0] r_q_pcp4  [DEPTH];

    logic w_req;
    logic w_grant;
    logic w_rsp;
    logic w_push;
    logic w_id_valid;
    logic w_pop;

    // rst_n in the request term keeps the request low while reset is held,
    // since r_pc alone would otherwise look like a valid fetch.
    assign w_req      = !r_outstanding && (r_occ < DEPTH_C) && !redirect_valid && rst_n;
    assign w_grant    = w_req && imem_gnt;
    // Responses are only meaningful while a request is outstanding; a stray
    // rvalid (e.g. a late one after reset) is ignored.
    assign w_rsp      = imem_rvalid && r_outstanding;
    assign w_push     = w_rsp && !r_discard && !redirect_valid;
    assign w_id_valid = (r_occ != '0) && !redirect_valid;
    assign w_pop      = w_id_valid && id_ready;

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign id_valid    = w_id_valid;
    assign occupancy   = r_occ;
    // Head fields read as zero while empty so stale entries never leak out.
    assign id_instr    = (r_occ != '0) ? r_q_instr[r_head] : '0;
    assign id_pc       = (r_occ != '0) ? r_q_pc[r_head]    : '0;
    assign id_pc_plus4 = (r_occ != '0) ? r_q_pcp4[r_head]  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_req_addr    <= '0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_occ         <= '0;
            r_head        <= '0;
            r_tail        <= '0;
        end else if (redirect_valid) begin
            r_occ  <= '0;
            r_head <= '0;
            r_tail <= '0;
            r_pc   <= {redirect_pc[ADDR_W-1:2], 2'b00};
            if (r_outstanding) begin
                if (imem_rvalid) begin
                    // The in-flight response arrives now and is dropped here,
                    // so nothing is left to squash later.
                    r_outstanding <= 1'b0;
                    r_discard     <= 1'b0;
                end else begin
                    r_discard <= 1'b1;
                end
            end
        end else begin
            // Grant and response are mutually exclusive: issue needs
            // !r_outstanding, a response needs r_outstanding.
            if (w_grant) begin
                r_req_addr    <= r_pc;
                r_pc          <= r_pc + WORD_INC;
                r_outstanding <= 1'b1;
            end
            if (w_rsp) begin
                r_outstanding <= 1'b0;
                r_discard     <= 1'b0;
            end
            if (w_push) begin
                r_tail <= (r_tail == LAST_PTR) ? '0 : r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= (r_head == LAST_PTR) ? '0 : r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only visible through r_occ.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_tail] <= imem_rdata;
            r_q_pc[r_tail]    <= r_req_addr;
            r_q_pcp4[r_tail]  <= r_req_addr + WORD_INC;
        end
    end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// tb/tb_mips_fetch_queue.sv - directed self-checking bench for mips_fetch_queue
module tb_mips_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [2:0]  occupancy;

    int total;
    int bad;

    // When set, memory answers every grant exactly one cycle later with ~addr.
    logic        auto_mem;
    logic [31:0] grant_log [$];
    logic [31:0] pop_pc    [$];
    logic [31:0] pop_pcp4  [$];
    logic [31:0] pop_instr [$];

    mips_fetch_queue #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0000_0040)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called mid-cycle once inputs are set: logs handshakes, crosses the edge,
    // then leaves us 1 time unit after the edge.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        #1;
        g = imem_req && imem_gnt;
        a = imem_addr;
        if (g) grant_log.push_back(a);
        if (id_valid && id_ready) begin
            pop_pc.push_back(id_pc);
            pop_pcp4.push_back(id_pc_plus4);
            pop_instr.push_back(id_instr);
        end
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_rvalid = g;
            imem_rdata  = g ? ~a : 32'h0;
        end
    endtask

    task automatic clear_logs();
        grant_log.delete();
        pop_pc.delete();
        pop_pcp4.delete();
        pop_instr.delete();
    endtask

    task automatic do_reset();
        auto_mem       = 1'b0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        id_ready       = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid got=%b exp=0", id_valid); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
        total++; if (id_pc !== 32'h0 || id_instr !== 32'h0 || id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL rst_id_fields got=%h/%h/%h exp=0", id_pc, id_instr, id_pc_plus4); end
        total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL rst_addr got=%h exp=00000040", imem_addr); end
        rst_n = 1'b1;
        #1;
        // Without a grant the request must hold with a stable address.
        tick();
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL hold_req got=%b/%h exp=1/00000040", imem_req, imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        auto_mem = 1'b1;
        imem_gnt = 1'b1;
        id_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        total++; if (grant_log.size() !== 6) begin bad++; $display("FAIL stream_grants got=%0d exp=6", grant_log.size()); end
        total++; if (pop_pc.size() !== 5) begin bad++; $display("FAIL stream_pops got=%0d exp=5", pop_pc.size()); end
        for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
            total++; if (grant_log[k] !== 32'h40 + 32'(4*k)) begin bad++; $display("FAIL stream_addr[%0d] got=%h exp=%h", k, grant_log[k], 32'h40 + 32'(4*k)); end
        end
        for (int k = 0; k < 5 && k < pop_pc.size(); k++) begin
            total++; if (pop_pc[k] !== 32'h40 + 32'(4*k)) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", k, pop_pc[k], 32'h40 + 32'(4*k)); end
            total++; if (pop_pcp4[k] !== 32'h44 + 32'(4*k)) begin bad++; $display("FAIL stream_pcp4[%0d] got=%h exp=%h", k, pop_pcp4[k], 32'h44 + 32'(4*k)); end
            total++; if (pop_instr[k] !== ~(32'h40 + 32'(4*k))) begin bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", k, pop_instr[k], ~(32'h40 + 32'(4*k))); end
        end
    endtask

    task automatic test_fill();
        do_reset();
        auto_mem = 1'b1;
        imem_gnt = 1'b1;
        id_ready = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        total++; if (grant_log.size() !== 4) begin bad++; $display("FAIL fill_grants got=%0d exp=4", grant_log.size()); end
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL fill_occ got=%0d exp=4", occupancy); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fill_req got=%b exp=0", imem_req); end
        id_ready = 1'b1;
        tick();
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL drain_occ1 got=%0d exp=3", occupancy); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h50) begin bad++; $display("FAIL drain_resume got=%b/%h exp=1/00000050", imem_req, imem_addr); end
        tick();
        total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL drain_occ2 got=%0d exp=2", occupancy); end
    endtask

    task automatic test_redirect_late();
        do_reset();
        imem_gnt = 1'b1;
        id_ready = 1'b1;
        tick();                       // grant 0x40
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_req_low got=%b exp=0", imem_req); end
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL redir_occ got=%0d exp=0", occupancy); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_wait got=%b exp=0", imem_req); end
        tick();
        imem_rvalid = 1'b1;           // squashed response, 3 cycles after grant
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        #1;
        total++; if (occupancy !== 3'd0 || id_valid !== 1'b0) begin bad++; $display("FAIL redir_drop got=%0d/%b exp=0/0", occupancy, id_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL redir_next got=%b/%h exp=1/00000100", imem_req, imem_addr); end
        tick();                       // grant 0x100
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        #1;
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_pc_plus4 !== 32'h104 || id_instr !== 32'h1234_5678) begin bad++; $display("FAIL redir_first got=%b/%h/%h/%h exp=1/00000100/00000104/12345678", id_valid, id_pc, id_pc_plus4, id_instr); end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        imem_gnt = 1'b1;
        tick();                       // grant 0x40
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hAAAA_0000;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        #1;
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL same_occ got=%0d exp=0", occupancy); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("FAIL same_next got=%b/%h exp=1/00000200", imem_req, imem_addr); end
        tick();                       // grant 0x200
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_5555;
        tick();
        imem_rvalid = 1'b0;
        #1;
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instr !== 32'h5555_5555) begin bad++; $display("FAIL same_first got=%b/%h/%h exp=1/00000200/55555555", id_valid, id_pc, id_instr); end
    endtask

    task automatic test_push_pop();
        do_reset();
        imem_gnt = 1'b1;
        tick();                       // grant 0x40
        imem_rvalid = 1'b1; imem_rdata = 32'hA0;
        tick();
        imem_rvalid = 1'b0;
        tick();                       // grant 0x44
        imem_rvalid = 1'b1; imem_rdata = 32'hA1;
        tick();
        imem_rvalid = 1'b0;
        tick();                       // grant 0x48
        imem_rvalid = 1'b1; imem_rdata = 32'hA2;
        id_ready    = 1'b1;
        #1;
        total++; if (occupancy !== 3'd2 || id_pc !== 32'h40) begin bad++; $display("FAIL pp_before got=%0d/%h exp=2/00000040", occupancy, id_pc); end
        tick();
        imem_rvalid = 1'b0;
        id_ready    = 1'b0;
        #1;
        total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL pp_occ got=%0d exp=2", occupancy); end
        total++; if (id_pc !== 32'h44 || id_instr !== 32'hA1) begin bad++; $display("FAIL pp_head got=%h/%h exp=00000044/000000a1", id_pc, id_instr); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        auto_mem       = 1'b1;
        imem_gnt       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++; if (grant_log.size() !== 2) begin bad++; $display("FAIL wrap_grants got=%0d exp=2", grant_log.size()); end
        if (grant_log.size() >= 2) begin
            total++; if (grant_log[0] !== 32'hFFFF_FFFC || grant_log[1] !== 32'h0) begin bad++; $display("FAIL wrap_addrs got=%h,%h exp=fffffffc,00000000", grant_log[0], grant_log[1]); end
        end
        total++; if (occupancy !== 3'd2 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0 || id_instr !== 32'h3) begin bad++; $display("FAIL wrap_head got=%0d/%h/%h/%h exp=2/fffffffc/00000000/00000003", occupancy, id_pc, id_pc_plus4, id_instr); end
        tick();                       // grant 0x4, response now pending
        auto_mem = 1'b0;
        rst_n    = 1'b0;
        #1;
        total++; if (id_valid !== 1'b0 || occupancy !== 3'd0 || id_pc !== 32'h0 || imem_req !== 1'b0) begin bad++; $display("FAIL midrst got=%b/%0d/%h/%b exp=0/0/00000000/0", id_valid, occupancy, id_pc, imem_req); end
        total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL midrst_addr got=%h exp=00000040", imem_addr); end
        rst_n = 1'b1;                 // late rvalid still high
        tick();
        imem_rvalid = 1'b0;
        #1;
        total++; if (occupancy !== 3'd0 || id_valid !== 1'b0) begin bad++; $display("FAIL late_rvalid got=%0d/%b exp=0/0", occupancy, id_valid); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stream();
        test_fill();
        test_redirect_late();
        test_redirect_same_cycle();
        test_push_pop();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
